// File: rtl/multiplicador_algoritmico.sv
// ============================================================================
//  Module   : multiplicador_algoritmico
//  Purpose  : Sequential signed shift-and-add multiply-accumulate, Num = Coc*Den + Res.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplicador_algoritmico #(
    parameter int tamanyo = 32,
    parameter int t_mod   = 5
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     Coc,
    input  logic [tamanyo-1:0]     Den,
    input  logic [tamanyo-1:0]     Res,
    output logic [2*tamanyo-1:0]   Num,
    output logic                   Done
);

    localparam logic [t_mod-1:0] c_cont_init = t_mod'(tamanyo - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_signc, w_signc_nxt;
    logic                   r_signd, w_signd_nxt;
    logic [tamanyo-1:0]     r_q,     w_q_nxt;
    logic [tamanyo-1:0]     r_m,     w_m_nxt;
    logic [tamanyo:0]       r_accu,  w_accu_nxt;
    logic [2*tamanyo-1:0]   r_res,   w_res_nxt;
    logic [t_mod-1:0]       r_cont,  w_cont_nxt;
    logic [2*tamanyo-1:0]   w_num_nxt;
    logic                   w_done_nxt;

    logic [tamanyo-1:0]     w_abs_coc;
    logic [tamanyo-1:0]     w_abs_den;
    logic [2*tamanyo:0]     w_shift;
    logic [2*tamanyo-1:0]   w_prod;
    logic [2*tamanyo-1:0]   w_prod_signed;

    // The most negative operand negates onto itself, which read as unsigned is its true magnitude.
    assign w_abs_coc     = Coc[tamanyo-1] ? (~Coc + 1'b1) : Coc;
    assign w_abs_den     = Den[tamanyo-1] ? (~Den + 1'b1) : Den;
    assign w_shift       = {r_accu, r_q} >> 1;
    assign w_prod        = {r_accu[tamanyo-1:0], r_q};
    assign w_prod_signed = (r_signc ^ r_signd) ? (~w_prod + 1'b1) : w_prod;

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            r_state <= S_IDLE;
            r_signc <= 1'b0;
            r_signd <= 1'b0;
            r_q     <= '0;
            r_m     <= '0;
            r_accu  <= '0;
            r_res   <= '0;
            r_cont  <= '0;
            Num     <= '0;
            Done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_signc <= w_signc_nxt;
            r_signd <= w_signd_nxt;
            r_q     <= w_q_nxt;
            r_m     <= w_m_nxt;
            r_accu  <= w_accu_nxt;
            r_res   <= w_res_nxt;
            r_cont  <= w_cont_nxt;
            Num     <= w_num_nxt;
            Done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_signc_nxt = r_signc;
        w_signd_nxt = r_signd;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_accu_nxt  = r_accu;
        w_res_nxt   = r_res;
        w_cont_nxt  = r_cont;
        w_num_nxt   = Num;
        w_done_nxt  = Done;

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_signc_nxt = Coc[tamanyo-1];
                    w_signd_nxt = Den[tamanyo-1];
                    w_q_nxt     = w_abs_coc;
                    w_m_nxt     = w_abs_den;
                    w_res_nxt   = {{tamanyo{Res[tamanyo-1]}}, Res};
                    w_accu_nxt  = '0;
                    w_cont_nxt  = c_cont_init;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (r_q[0]) begin
                    w_accu_nxt = r_accu + {1'b0, r_m};
                end
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_accu_nxt  = w_shift[2*tamanyo:tamanyo];
                w_q_nxt     = w_shift[tamanyo-1:0];
                w_cont_nxt  = r_cont - 1'b1;
                w_state_nxt = (r_cont == '0) ? S_FIN : S_ADD;
            end
            S_FIN: begin
                w_num_nxt   = w_prod_signed + r_res;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
